// File: rtl/brc_pkg.sv
// rtl/brc_pkg.sv - shared encodings for the branch/jump resolution controller
package brc_pkg;

    // Control-transfer op classes presented by decode/issue
    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_JAL    = 2'b01,
        OP_JALR   = 2'b10,
        OP_RSVD   = 2'b11
    } brc_op_e;

    // Conditional branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_EVAL     = 2'b01,
        ST_REDIRECT = 2'b10,
        ST_FLUSH    = 2'b11
    } brc_state_e;

    // Exception causes raised while evaluating an op
    localparam logic [1:0] EXC_NONE     = 2'd0;
    localparam logic [1:0] EXC_ILLEGAL  = 2'd1;
    localparam logic [1:0] EXC_MISALIGN = 2'd2;

    // JAL and JALR both write the link register
    function automatic logic is_jump(input logic [1:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluator
module branch_cmp
    import brc_pkg::*;
(
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [2:0]  i_funct3,
    output logic        o_cond,
    output logic        o_illegal
);

    logic w_eq;
    logic w_lt;
    logic w_ltu;

    assign w_eq  = (i_rs1 == i_rs2);
    assign w_lt  = ($signed(i_rs1) < $signed(i_rs2));
    assign w_ltu = (i_rs1 < i_rs2);

    // Select the condition named by funct3; 010/011 have no branch meaning
    always_comb begin
        o_cond    = 1'b0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_BEQ:  o_cond = w_eq;
            F3_BNE:  o_cond = !w_eq;
            F3_BLT:  o_cond = w_lt;
            F3_BGE:  o_cond = !w_lt;
            F3_BLTU: o_cond = w_ltu;
            F3_BGEU: o_cond = !w_ltu;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - branch/jump resolution controller (optional BRC_STATIC_PREDICT_EN)
module branch_ctrl
    import brc_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        BRC_CLOCK_50,
    input  logic        BRC_RESET_InLow,
    input  logic        BRC_valid_In,
    output logic        BRC_ready_Out,
    input  logic [1:0]  BRC_op_InBUS,
    input  logic [2:0]  BRC_funct3_InBUS,
    input  logic [31:0] BRC_pc_InBUS,
    input  logic [31:0] BRC_imm_InBUS,
    input  logic [31:0] BRC_rs1_data_InBUS,
    input  logic [31:0] BRC_rs2_data_InBUS,
`ifdef BRC_STATIC_PREDICT_EN
    input  logic        BRC_pred_taken_In,
`endif
    input  logic        BRC_fetch_ack_In,
    output logic        BRC_redirect_Out,
    output logic [31:0] BRC_target_OutBUS,
    output logic        BRC_flush_Out,
    output logic        BRC_link_we_Out,
    output logic [31:0] BRC_link_OutBUS,
    output logic        BRC_exc_Out
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    brc_state_e  r_state;
    brc_state_e  w_next_state;
    logic [1:0]  r_op;
    logic [2:0]  r_funct3;
    logic [31:0] r_pc;
    logic [31:0] r_imm;
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [31:0] r_target;
    logic [31:0] r_link;
    logic [3:0]  r_flush_cnt;
`ifdef BRC_STATIC_PREDICT_EN
    logic        r_pred;
`endif

    logic        w_cond;
    logic        w_cmp_illegal;
    logic [31:0] w_sum_pc_imm;
    logic [31:0] w_sum_rs1_imm;
    logic [31:0] w_target_taken;
    logic [31:0] w_target;
    logic        w_illegal;
    logic        w_taken;
    logic        w_misalign;
    logic [1:0]  w_cause;
    logic        w_redirect_needed;
    logic        w_go_redirect;

    branch_cmp u_cmp (
        .i_rs1     (r_rs1),
        .i_rs2     (r_rs2),
        .i_funct3  (r_funct3),
        .o_cond    (w_cond),
        .o_illegal (w_cmp_illegal)
    );

    // Resolve the captured op: condition, target, exception cause and redirect decision
    always_comb begin
        w_sum_pc_imm   = r_pc + r_imm;
        w_sum_rs1_imm  = r_rs1 + r_imm;
        w_target_taken = (r_op == OP_JALR) ? (w_sum_rs1_imm & ~32'd1) : w_sum_pc_imm;
        w_illegal      = (r_op == OP_RSVD) || ((r_op == OP_BRANCH) && w_cmp_illegal);
        w_taken        = !w_illegal && ((r_op == OP_BRANCH) ? w_cond : 1'b1);
        w_misalign     = w_taken && w_target_taken[1];
        if (w_illegal)
            w_cause = EXC_ILLEGAL;
        else if (w_misalign)
            w_cause = EXC_MISALIGN;
        else
            w_cause = EXC_NONE;
`ifdef BRC_STATIC_PREDICT_EN
        // A wrong taken-prediction sends fetch back to the fall-through address
        w_redirect_needed = (w_taken != r_pred);
        w_target          = (r_pred && !w_taken) ? (r_pc + 32'd4) : w_target_taken;
`else
        w_redirect_needed = w_taken;
        w_target          = w_target_taken;
`endif
        w_go_redirect = (w_cause == EXC_NONE) && w_redirect_needed;
    end

    // State register
    always_ff @(posedge BRC_CLOCK_50 or negedge BRC_RESET_InLow) begin
        if (!BRC_RESET_InLow)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state     = r_state;
        BRC_ready_Out    = 1'b0;
        BRC_redirect_Out = 1'b0;
        BRC_flush_Out    = 1'b0;
        BRC_link_we_Out  = 1'b0;
        BRC_exc_Out      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                BRC_ready_Out = 1'b1;
                if (BRC_valid_In)
                    w_next_state = ST_EVAL;
            end
            ST_EVAL: begin
                BRC_link_we_Out = is_jump(r_op);
                BRC_exc_Out     = (w_cause != EXC_NONE);
                w_next_state    = w_go_redirect ? ST_REDIRECT : ST_IDLE;
            end
            ST_REDIRECT: begin
                BRC_redirect_Out = 1'b1;
                BRC_flush_Out    = 1'b1;
                if (BRC_fetch_ack_In)
                    w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                BRC_flush_Out = 1'b1;
                if (r_flush_cnt == 4'd0)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, held redirect target and flush counter
    always_ff @(posedge BRC_CLOCK_50 or negedge BRC_RESET_InLow) begin
        if (!BRC_RESET_InLow) begin
            r_op        <= 2'd0;
            r_funct3    <= 3'd0;
            r_pc        <= 32'd0;
            r_imm       <= 32'd0;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_target    <= 32'd0;
            r_link      <= 32'd0;
            r_flush_cnt <= 4'd0;
`ifdef BRC_STATIC_PREDICT_EN
            r_pred      <= 1'b0;
`endif
        end else begin
            if (r_state == ST_IDLE && BRC_valid_In) begin
                r_op     <= BRC_op_InBUS;
                r_funct3 <= BRC_funct3_InBUS;
                r_pc     <= BRC_pc_InBUS;
                r_imm    <= BRC_imm_InBUS;
                r_rs1    <= BRC_rs1_data_InBUS;
                r_rs2    <= BRC_rs2_data_InBUS;
                r_link   <= BRC_pc_InBUS + 32'd4;
`ifdef BRC_STATIC_PREDICT_EN
                r_pred   <= BRC_pred_taken_In;
`endif
            end
            if (r_state == ST_EVAL && w_go_redirect)
                r_target <= w_target;
            if (r_state == ST_REDIRECT && BRC_fetch_ack_In)
                r_flush_cnt <= FLUSH_LOAD;
            else if (r_state == ST_FLUSH && r_flush_cnt != 4'd0)
                r_flush_cnt <= r_flush_cnt - 4'd1;
        end
    end

    assign BRC_target_OutBUS = r_target;
    assign BRC_link_OutBUS   = r_link;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch/jump resolution controller for the RISC-V core. It accepts one control-transfer op at a time from decode/issue and captures its operands. It evaluates the condition through an internal comparator and computes the target. On a required redirect it drives the fetch stage with a held redirect/target handshake, then asserts a pipeline flush for a fixed number of cycles before accepting the next op.

## Interface
- FLUSH_CYCLES, 2: cycles of BRC_flush_Out after the redirect is acknowledged (1..15).
- BRC_CLOCK_50  in  1  single clock, rising edge.
- BRC_RESET_InLow  in  1  asynchronous, active-low reset.
- BRC_valid_In  in  1  op offered.
- BRC_ready_Out  out  1  controller can accept an op.
- BRC_op_InBUS  in  2  00 conditional branch, 01 JAL, 10 JALR, 11 reserved.
- BRC_funct3_InBUS  in  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- BRC_pc_InBUS  in  32  PC of the op.
- BRC_imm_InBUS  in  32  sign-extended offset.
- BRC_rs1_data_InBUS  in  32  rs1 value.
- BRC_rs2_data_InBUS  in  32  rs2 value.
- BRC_fetch_ack_In  in  1  fetch has taken the redirect.
- BRC_redirect_Out  out  1  redirect request to fetch.
- BRC_target_OutBUS  out  32  redirect address.
- BRC_flush_Out  out  1  squash younger instructions.
- BRC_link_we_Out  out  1  one-cycle rd write strobe for JAL/JALR.
- BRC_link_OutBUS  out  32  pc+4.
- BRC_exc_Out  out  1  one-cycle pulse on misaligned target or illegal op/funct3.

## Operation
- States: IDLE, EVAL, REDIRECT, FLUSH.
- IDLE:
  - BRC_ready_Out=1.
  - On valid&ready, register op, funct3, pc, imm, rs1 and rs2, then go to EVAL.
- EVAL:
  - taken = comparator result for op 00, always 1 for JAL/JALR.
  - Target:
    - op 00/01: pc+imm.
    - JALR: (rs1+imm) with bit0 forced to 0.
    - All sums mod 2^32, wrap silently.
  - link = pc+4 (mod 2^32). BRC_link_we_Out pulses this cycle for JAL/JALR.
  - Illegal cases: op 11, or funct3 010/011 on op 00. Result: taken=0, BRC_exc_Out pulses, no link write, go to IDLE.
  - Misalignment: taken and target[1]=1 means BRC_exc_Out pulses, no redirect, go to IDLE. The JAL/JALR link write still occurs.
  - redirect_needed → REDIRECT. Otherwise → IDLE.
- REDIRECT:
  - BRC_redirect_Out=1 and BRC_flush_Out=1, with BRC_target_OutBUS held stable.
  - On BRC_fetch_ack_In=1, load the flush counter with FLUSH_CYCLES-1 and go to FLUSH.
  - Wait indefinitely otherwise.
- FLUSH:
  - BRC_flush_Out=1 and the counter decrements.
  - At 0, go to IDLE.
- BRC_fetch_ack_In is ignored outside REDIRECT.

## Timing
- Reset values:
  - State: IDLE.
  - BRC_ready_Out=1.
  - BRC_redirect_Out, BRC_flush_Out, BRC_link_we_Out, BRC_exc_Out all 0.
  - BRC_target_OutBUS and BRC_link_OutBUS 0.
  - All operand registers 0.
- Reset asserted mid-operation aborts immediately to reset values. A pending redirect is dropped.
- Accept at edge N. EVAL runs in cycle N+1. Redirect is visible from N+2.
- Not-taken throughput: one op per 2 cycles.
- Ack in the first REDIRECT cycle: flush is high from N+2 through N+2+FLUSH_CYCLES, and ready returns the cycle after.
- All outputs are registered or decoded from state. No combinational path from any input to any output.

## Configuration
- BRC_STATIC_PREDICT_EN defined:
  - Adds input BRC_pred_taken_In (1 bit), captured with the op.
  - redirect_needed = (taken != pred_taken).
  - Predicted taken but not taken: target = pc+4, and no misalignment check applies.
  - Correct prediction: no redirect and no flush.
- Undefined:
  - Port absent.
  - redirect_needed = taken.

## Structure
- Package brc_pkg holds:
  - Op encodings.
  - funct3 localparams.
  - State encoding (2-bit).
  - Exception cause constants.
- Sub-module branch_cmp: purely combinational condition evaluator taking rs1, rs2 and funct3. It returns cond and illegal.
- FSM, counter, adders and handshake stay in branch_ctrl.

## Test plan
- BEQ, rs1=rs2=0x5, pc=0x100, imm=0x20, ack on first REDIRECT cycle: redirect from N+2, target=0x120, flush 3 cycles (FLUSH_CYCLES=2), ready back at N+5.
- BLT, rs1=0xFFFFFFFF, rs2=0x1: taken. BLTU with the same operands: not taken, no redirect, ready at N+2.
- JALR, rs1=0x203, imm=0x1, pc=0x40: target=0x204, link_we pulse, link=0x44. JAL with pc=0x0, imm=0x6: exc pulse, no redirect, link still written.
- Hold BRC_fetch_ack_In=0 for 5 cycles: redirect and target stable and ready=0 throughout. Assert reset in the 3rd cycle: all outputs go to reset values asynchronously.
- funct3=011 on op 00: exc pulse, no redirect. Also pc=0xFFFFFFFC, imm=0x8 taken: target wraps to 0x4.
- With BRC_STATIC_PREDICT_EN, BNE not taken but pred_taken=1, pc=0x80: redirect to 0x84. Correct prediction: no redirect.
